// File: rtl/link_tx_scheduler.sv
// link_tx_scheduler
//   Shares the single inter-board serial wire between four message sources (connect, start,
//   game-finish, cell-update). Each request is latched as pending, one pending message is granted
//   at a time by fixed priority (finish > start > connect > cell), and the granted message is
//   serialized LSB first as: START(0) | id[1:0] | payload | [parity] | STOP(1).
//   Every bit lasts BIT_CYCLES clocks.
//
//   Optional feature macro: LINK_PARITY_EN
//     defined   -> an even-parity bit over id and payload is sent between DATA and STOP
//     undefined -> DATA goes straight to STOP
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high
//   link_enable_i   1 = new frames may be granted; a frame in progress always completes
//   req_connect_i   request pulse, msg id 0
//   req_start_i     request pulse, msg id 1
//   req_finish_i    request pulse, msg id 2
//   req_cell_i      request pulse, msg id 3; cell_payload_i sampled on the same edge
//   cell_payload_i  cell-update payload: cell index [6:0], digit [10:7]
//   link_tx_o       registered serial line, idle high
//   busy_o          high from START through the end of STOP
//   grant_o         one-hot {cell,finish,start,connect}, pulsed in the first START cycle
//   frame_done_o    pulse in the first IDLE cycle after STOP
//   cell_dropped_o  pulse when req_cell overwrites a still-pending cell payload
module link_tx_scheduler #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned PAYLOAD_W  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 link_enable_i,
  input  logic                 req_connect_i,
  input  logic                 req_start_i,
  input  logic                 req_finish_i,
  input  logic                 req_cell_i,
  input  logic [PAYLOAD_W-1:0] cell_payload_i,
  output logic                 link_tx_o,
  output logic                 busy_o,
  output logic [3:0]           grant_o,
  output logic                 frame_done_o,
  output logic                 cell_dropped_o
);

  localparam int unsigned TimerW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned CntW   = $clog2(PAYLOAD_W + 1);
`ifdef LINK_PARITY_EN
  localparam int unsigned FrameW = PAYLOAD_W + 3;
`else
  localparam int unsigned FrameW = PAYLOAD_W + 2;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StId, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [FrameW-1:0]    shift_q, shift_d;
  logic [3:0]           pend_q, pend_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 link_tx_q, link_tx_d;
  logic                 busy_q, busy_d;
  logic [3:0]           grant_q, grant_d;
  logic                 frame_done_q, frame_done_d;
  logic                 dropped_q, dropped_d;

  logic [3:0]           req;
  logic [3:0]           sel;
  logic [3:0]           gnt;
  logic                 start_frame;
  logic                 bit_end;
  logic [1:0]           sel_id;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [FrameW-1:0]    frame_load;

  assign req = {req_cell_i, req_finish_i, req_start_i, req_connect_i};

  // Fixed priority: finish > start > connect > cell.
  always_comb begin
    sel = 4'b0000;
    if (pend_q[2])      sel = 4'b0100;
    else if (pend_q[1]) sel = 4'b0010;
    else if (pend_q[0]) sel = 4'b0001;
    else if (pend_q[3]) sel = 4'b1000;
  end

  assign start_frame = (state_q == StIdle) && link_enable_i && (pend_q != 4'b0000);
  assign gnt         = start_frame ? sel : 4'b0000;
  assign bit_end     = (timer_q == TimerW'(BIT_CYCLES - 1));

  assign sel_id      = {sel[3] | sel[2], sel[3] | sel[1]};
  assign sel_payload = sel[3] ? payload_q : '0;
`ifdef LINK_PARITY_EN
  assign frame_load  = {^{sel_payload, sel_id}, sel_payload, sel_id};
`else
  assign frame_load  = {sel_payload, sel_id};
`endif

  // Pending flags: a request on the granting edge re-sets the flag (set wins).
  always_comb begin
    pend_d    = (pend_q & ~gnt) | req;
    payload_d = req_cell_i ? cell_payload_i : payload_q;
    // A cell being granted on this edge has already been captured, so it is not dropped.
    dropped_d = req_cell_i & pend_q[3] & ~gnt[3];
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_frame) state_d = StStart;
      StStart:  if (bit_end) state_d = StId;
      StId:     if (bit_end && cnt_q == CntW'(1)) state_d = StData;
      StData: begin
        if (bit_end && cnt_q == CntW'(PAYLOAD_W - 1)) begin
`ifdef LINK_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (bit_end) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bit timer, bit counter and shift register.
  always_comb begin
    timer_d = (state_q == StIdle || bit_end) ? '0 : timer_q + 1'b1;
    if (state_d != state_q)  cnt_d = '0;
    else if (bit_end)        cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
    shift_d = shift_q;
    if (start_frame) begin
      shift_d = frame_load;
    end else if (bit_end && (state_q == StId || state_q == StData)) begin
      shift_d = shift_q >> 1;
    end
  end

  // FSM outputs, decoded from the next state so they come straight out of flops.
  always_comb begin
    link_tx_d    = 1'b1;
    busy_d       = (state_d != StIdle);
    grant_d      = gnt;
    frame_done_d = (state_q == StStop) && (state_d == StIdle);
    unique case (state_d)
      StStart:                link_tx_d = 1'b0;
      StId, StData, StParity: link_tx_d = shift_d[0];
      default:                link_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q      <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      pend_q       <= 4'b0000;
      payload_q    <= '0;
      link_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 4'b0000;
      frame_done_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      payload_q    <= payload_d;
      link_tx_q    <= link_tx_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      frame_done_q <= frame_done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign link_tx_o      = link_tx_q;
  assign busy_o         = busy_q;
  assign grant_o        = grant_q;
  assign frame_done_o   = frame_done_q;
  assign cell_dropped_o = dropped_q;

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Scoreboard bench for link_tx_scheduler (BIT_CYCLES=4, PAYLOAD_W=11).
// A frame-level reference model predicts grants, serialized frames and drop pulses; monitors
// pop the expectations whenever the DUT pulses grant or cell_dropped.
module tb_link_tx_scheduler;

  localparam int BC = 4;
  localparam int W  = 11;
`ifdef LINK_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 4 + W + P;
  localparam int L     = NBITS * BC;

  logic         clk = 1'b0;
  logic         reset;
  logic         link_enable;
  logic         req_connect, req_start, req_finish, req_cell;
  logic [W-1:0] cell_payload;
  logic         link_tx, busy, frame_done, cell_dropped;
  logic [3:0]   grant;

  link_tx_scheduler #(.BIT_CYCLES(BC), .PAYLOAD_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .link_enable_i (link_enable),
    .req_connect_i (req_connect),
    .req_start_i   (req_start),
    .req_finish_i  (req_finish),
    .req_cell_i    (req_cell),
    .cell_payload_i(cell_payload),
    .link_tx_o     (link_tx),
    .busy_o        (busy),
    .grant_o       (grant),
    .frame_done_o  (frame_done),
    .cell_dropped_o(cell_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  gnt;
    int          edge_i;
    logic [31:0] bits;   // line value per bit, LSB = first bit on the wire
  } frame_t;

  frame_t     exp_q[$];
  int         drop_q[$];
  logic [3:0] pend_m = 4'b0000;
  logic [W-1:0] pay_m = '0;
  int         ret_m  = 0;  // first edge at which a new grant is possible

  function automatic logic [31:0] build_frame(input int id, input logic [W-1:0] p);
    logic [31:0] b;
    int n;
    b = '0;
    n = 0;
    b[n] = 1'b0;              n++;
    b[n] = (id % 2) == 1;     n++;
    b[n] = (id / 2) == 1;     n++;
    for (int j = 0; j < W; j++) begin
      b[n] = p[j];
      n++;
    end
    if (P == 1) begin
      b[n] = (($countones(id) + $countones(p)) % 2) == 1;
      n++;
    end
    b[n] = 1'b1;
    return b;
  endfunction

  // Advance the model by one clock edge with the inputs about to be sampled.
  task automatic model_edge(input logic [3:0] r, input logic en, input logic [W-1:0] pl);
    int k;
    int pri[4];
    bit found;
    frame_t f;
    k = cyc + 1;
    pri = '{2, 1, 0, 3};
    found = 0;
    if (k >= ret_m && en && pend_m != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (!found && pend_m[pri[i]]) begin
          found = 1;
          f.gnt = 4'b0001 << pri[i];
          f.edge_i = k;
          f.bits = build_frame(pri[i], (pri[i] == 3) ? pay_m : '0);
          exp_q.push_back(f);
          pend_m[pri[i]] = 1'b0;
          ret_m = k + L + 1;
        end
      end
    end
    if (r[3] && pend_m[3]) drop_q.push_back(k);
    pend_m = pend_m | r;
    if (r[3]) pay_m = pl;
  endtask

  task automatic model_reset();
    pend_m = 4'b0000;
    pay_m  = '0;
    ret_m  = 0;
    exp_q.delete();
    drop_q.delete();
  endtask

  // r = {cell, finish, start, connect}
  task automatic drive(input logic [3:0] r, input logic en, input logic [W-1:0] pl);
    @(negedge clk);
    {req_cell, req_finish, req_start, req_connect} = r;
    link_enable  = en;
    cell_payload = pl;
    model_edge(r, en, pl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'b0000, 1'b1, W'($urandom_range(0, 2047)));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((pend_m != 4'b0000 || cyc + 1 < ret_m) && t < 2000) begin
      idle(1);
      t++;
    end
    chk("drain_timeout", (t >= 2000), 0);
    idle(3);
  endtask

  // ---------------- frame monitor ----------------
  initial begin : frame_mon
    frame_t e;
    int errs;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) continue;
      if (grant !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", grant, 4'b0000);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", grant, e.gnt);
          chk("grant_time", cyc, e.edge_i);
          errs = 0;
          aborted = 0;
          for (int c = 0; c < L; c++) begin
            if (c > 0) @(negedge clk);
            if (reset) begin
              aborted = 1;
              break;
            end
            if (link_tx !== e.bits[c / BC] || busy !== 1'b1 || (c > 0 && grant !== 4'b0000))
              errs++;
          end
          if (!aborted) begin
            @(negedge clk);
            if (!reset) begin
              chk("frame_wave", errs, 0);
              chk("frame_done", {frame_done, busy, link_tx}, 3'b101);
            end
          end
        end
      end else begin
        chk("idle_line", {frame_done, busy, link_tx}, 3'b001);
      end
    end
  end

  // ---------------- drop monitor ----------------
  initial begin : drop_mon
    int k;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && cell_dropped === 1'b1) begin
        if (drop_q.size() == 0) begin
          chk("unexpected_drop", 1, 0);
        end else begin
          k = drop_q.pop_front();
          chk("drop_time", cyc, k);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic en_r;
    logic [3:0] r;
    reset = 1'b1;
    link_enable = 1'b0;
    {req_cell, req_finish, req_start, req_connect} = 4'b0000;
    cell_payload = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {link_tx, busy, grant, frame_done, cell_dropped}, 8'b1000_0000);
    reset = 1'b0;

    // Single cell frame with a known payload.
    drive(4'b1000, 1'b1, 11'h2A5);
    idle(70);

    // Three simultaneous requests served finish, connect, cell.
    drive(4'b1101, 1'b1, 11'h123);
    idle(200);

    // Blocked by link_enable, then released.
    drive(4'b0010, 1'b0, '0);
    for (int i = 0; i < 20; i++) drive(4'b0000, 1'b0, '0);
    chk("blocked_line", {busy, link_tx}, 2'b01);
    idle(70);

    // Two cell requests while a finish frame is on the wire.
    drive(4'b0100, 1'b1, '0);
    idle(10);
    drive(4'b1000, 1'b1, 11'h001);
    idle(5);
    drive(4'b1000, 1'b1, 11'h7FF);
    idle(140);

    // Randomized traffic.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = ~en_r;
      r[0] = ($urandom_range(0, 39) == 0);
      r[1] = ($urandom_range(0, 39) == 0);
      r[2] = ($urandom_range(0, 39) == 0);
      r[3] = ($urandom_range(0, 14) == 0);
      drive(r, en_r, W'($urandom_range(0, 2047)));
    end
    drain();
    chk("frames_left", exp_q.size(), 0);
    chk("drops_left", drop_q.size(), 0);

    // Reset in the middle of a frame.
    drive(4'b0100, 1'b1, '0);
    idle(21);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_abort", {busy, link_tx, grant}, 6'b010000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(100);
    chk("post_reset_quiet", {busy, link_tx}, 2'b01);

    // Recovery after reset.
    drive(4'b0001, 1'b1, '0);
    drain();
    chk("frames_left_end", exp_q.size(), 0);
    chk("drops_left_end", drop_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
